sysbus_arbiter: RTL and testbench

//  Shares the single 64-bit system memory bus between NUM_REQ cache masters (port 0 icache, port 1 dcache).

---
 rtl/sysbus_arb_pkg.sv | 16 +
 rtl/sysbus_arbiter_rr_pick.sv | 39 +++
 rtl/sysbus_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sysbus_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbus_arb_pkg.sv
// Shared types for the system bus arbiter: FSM state encoding and owner-index width helper.
package sysbus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANTED,
    ARB_BUSY,
    ARB_RELEASE
  } arb_state_e;

  // Width of an index into num_req masters; never narrower than one bit.
  function automatic int owner_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/sysbus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NUM_REQ.
module rr_pick
  import sysbus_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int OWNER_W = owner_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [OWNER_W-1:0] idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   pos;

  // Rotate so that the master at ptr lands in bit 0.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_REQ-1:0];

  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = 0;
    // Walk downwards so the smallest offset from ptr is the last (winning) write.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        pos = int'(ptr) + k;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        idx = OWNER_W'(pos);
      end
    end
    gnt = any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/sysbus_arbiter.sv
// Round-robin owner arbiter for the shared system memory bus; whole-transaction ownership.
// Define SYSBUS_ARB_WDOG_EN to add a BUSY watchdog that releases a hung owner after WDOG_CYCLES.
module sysbus_arbiter
  import sysbus_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int START_TIMEOUT  = 16,
  parameter int WDOG_CYCLES    = 1024
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                m_busreq,
  input  logic [NUM_REQ-1:0]                m_busidle,
  output logic [NUM_REQ-1:0]                m_busgrant,
  input  logic [NUM_REQ-1:0]                m_reqcyc,
  input  logic [NUM_REQ-1:0]                m_respack,
  input  logic [NUM_REQ*BUS_DATA_WIDTH-1:0] m_req,
  input  logic [NUM_REQ*BUS_TAG_WIDTH-1:0]  m_reqtag,
  output logic [NUM_REQ-1:0]                m_reqack,
  output logic [NUM_REQ-1:0]                m_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]         m_resp,
  output logic [BUS_TAG_WIDTH-1:0]          m_resptag,
  output logic                              bus_reqcyc,
  output logic                              bus_respack,
  output logic [BUS_DATA_WIDTH-1:0]         bus_req,
  output logic [BUS_TAG_WIDTH-1:0]          bus_reqtag,
  input  logic                              bus_reqack,
  input  logic                              bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0]         bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]          bus_resptag,
  output logic                              arb_error
);

  localparam int DW   = BUS_DATA_WIDTH;
  localparam int TW   = BUS_TAG_WIDTH;
  localparam int OW   = owner_w(NUM_REQ);
  localparam int SC_W = $clog2(START_TIMEOUT + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || START_TIMEOUT < 1 || WDOG_CYCLES < 1) begin : g_param_check
    $error("sysbus_arbiter: unsupported parameter value");
  end

  logic [DW-1:0] req_arr [NUM_REQ];
  logic [TW-1:0] tag_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_arr[gi] = m_req[gi*DW +: DW];
    assign tag_arr[gi] = m_reqtag[gi*TW +: TW];
  end

  arb_state_e         state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               err_q, err_d;
  logic [SC_W-1:0]    start_cnt_q, start_cnt_d;
`ifdef SYSBUS_ARB_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0]    wdog_cnt_q, wdog_cnt_d;
`endif

  logic [NUM_REQ-1:0] pick_gnt;
  logic [OW-1:0]      pick_idx;
  logic               pick_any;
  logic               own_idle;
  logic               bus_active;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .OWNER_W (OW)
  ) u_rr_pick (
    .req (m_busreq),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign own_idle = m_busidle[owner_q];

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    err_d       = err_q;
    start_cnt_d = start_cnt_q;
`ifdef SYSBUS_ARB_WDOG_EN
    wdog_cnt_d  = wdog_cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d     = ARB_GRANTED;
          owner_d     = pick_idx;
          grant_d     = pick_gnt;
          start_cnt_d = '0;
        end
      end
      ARB_GRANTED: begin
        if (!own_idle) begin
          state_d     = ARB_BUSY;
          start_cnt_d = '0;
`ifdef SYSBUS_ARB_WDOG_EN
          wdog_cnt_d  = '0;
`endif
        end else if (start_cnt_q == SC_W'(START_TIMEOUT - 1)) begin
          // Owner never started a transaction: revoke so other masters are not starved.
          state_d     = ARB_RELEASE;
          grant_d     = '0;
          err_d       = 1'b1;
          start_cnt_d = '0;
        end else if (start_cnt_q != SC_W'(START_TIMEOUT)) begin
          start_cnt_d = start_cnt_q + SC_W'(1);
        end
      end
      ARB_BUSY: begin
        // A response still on the bus keeps ownership even if the master reports idle.
        if (own_idle && !bus_respcyc) begin
          state_d = ARB_RELEASE;
          grant_d = '0;
`ifdef SYSBUS_ARB_WDOG_EN
        end else if (wdog_cnt_q == WD_W'(WDOG_CYCLES - 1)) begin
          state_d    = ARB_RELEASE;
          grant_d    = '0;
          err_d      = 1'b1;
          wdog_cnt_d = '0;
        end else if (wdog_cnt_q != WD_W'(WDOG_CYCLES)) begin
          wdog_cnt_d = wdog_cnt_q + WD_W'(1);
`endif
        end
      end
      ARB_RELEASE: begin
        state_d  = ARB_IDLE;
        rr_ptr_d = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + OW'(1);
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      err_q       <= 1'b0;
      start_cnt_q <= '0;
`ifdef SYSBUS_ARB_WDOG_EN
      wdog_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
      start_cnt_q <= start_cnt_d;
`ifdef SYSBUS_ARB_WDOG_EN
      wdog_cnt_q  <= wdog_cnt_d;
`endif
    end
  end

  // Reset forces the bus quiet immediately rather than waiting for the state to clear.
  assign bus_active = ((state_q == ARB_GRANTED) || (state_q == ARB_BUSY)) && !reset;

  always_comb begin
    bus_reqcyc  = 1'b0;
    bus_respack = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    m_reqack    = '0;
    m_respcyc   = '0;
    if (bus_active) begin
      bus_reqcyc         = m_reqcyc[owner_q];
      bus_respack        = m_respack[owner_q];
      bus_req            = req_arr[owner_q];
      bus_reqtag         = tag_arr[owner_q];
      m_reqack[owner_q]  = bus_reqack;
      m_respcyc[owner_q] = bus_respcyc;
    end
  end

  assign m_resp     = bus_resp;
  assign m_resptag  = bus_resptag;
  assign m_busgrant = grant_q;
  assign arb_error  = err_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Self-checking bench for sysbus_arbiter: directed vector table, corner sequences, random vs. model.
module tb_sysbus_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int TW = 13;
  localparam int ST = 16;
  localparam int WD = 32;

  logic            clk, reset;
  logic [N-1:0]    m_busreq, m_busidle, m_busgrant, m_reqcyc, m_respack, m_reqack, m_respcyc;
  logic [N*DW-1:0] m_req;
  logic [N*TW-1:0] m_reqtag;
  logic [DW-1:0]   m_resp, bus_req, bus_resp;
  logic [TW-1:0]   m_resptag, bus_reqtag, bus_resptag;
  logic            bus_reqcyc, bus_respack, bus_reqack, bus_respcyc, arb_error;

  int checks = 0;
  int errors = 0;

  sysbus_arbiter #(
    .NUM_REQ(N), .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW),
    .START_TIMEOUT(ST), .WDOG_CYCLES(WD)
  ) dut (
    .clk(clk), .reset(reset),
    .m_busreq(m_busreq), .m_busidle(m_busidle), .m_busgrant(m_busgrant),
    .m_reqcyc(m_reqcyc), .m_respack(m_respack), .m_req(m_req), .m_reqtag(m_reqtag),
    .m_reqack(m_reqack), .m_respcyc(m_respcyc), .m_resp(m_resp), .m_resptag(m_resptag),
    .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .arb_error(arb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m_busreq = '0; m_busidle = '1; bus_respcyc = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Behavioural model: who owns the bus and what phase of ownership it is in.
  int own, waited, busy_len, ptr;
  bit dead, in_txn, err_m;

  task automatic model_reset();
    own = -1; dead = 0; in_txn = 0; waited = 0; busy_len = 0; ptr = 0; err_m = 0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (dead) begin
      ptr = (own + 1) % N;
      own = -1;
      dead = 0;
    end else if (own < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr + k) % N;
        if (m_busreq[i] && own < 0) own = i;
      end
      waited = 0; in_txn = 0;
    end else if (!in_txn) begin
      if (!m_busidle[own]) begin
        in_txn = 1; busy_len = 0;
      end else begin
        waited++;
        if (waited >= ST) begin dead = 1; err_m = 1; end
      end
    end else begin
      busy_len++;
      if (m_busidle[own] && !bus_respcyc) dead = 1;
`ifdef SYSBUS_ARB_WDOG_EN
      else if (busy_len >= WD) begin dead = 1; err_m = 1; end
`endif
    end
  endtask

  task automatic model_check();
    bit active;
    logic [N-1:0]  eg, eack, ecyc;
    logic [127:0]  efwd;
    active = (own >= 0) && !dead;
    eg = active ? N'(1 << own) : '0;
    efwd = '0; eack = '0; ecyc = '0;
    if (active && !reset) begin
      efwd = {m_reqcyc[own], m_respack[own], m_req[own*DW +: DW], m_reqtag[own*TW +: TW]};
      eack[own] = bus_reqack;
      ecyc[own] = bus_respcyc;
    end
    chk("rnd_grant", m_busgrant, eg);
    chk("rnd_busfwd", {bus_reqcyc, bus_respack, bus_req, bus_reqtag}, efwd);
    chk("rnd_route", {m_reqack, m_respcyc}, {eack, ecyc});
    chk("rnd_err", arb_error, err_m);
  endtask

  typedef struct {
    logic [N-1:0] busreq;
    logic [N-1:0] busidle;
    logic         respcyc;
    logic [N-1:0] exp_grant;
    logic         exp_reqcyc;
    logic [N-1:0] exp_mresp;
    logic         exp_err;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [DW-1:0] req0, req1, exp_req;
    int held;

    req0 = 64'hA0A0_0000_1111_0000;
    req1 = 64'hB1B1_0000_2222_0001;
    // busreq busidle respcyc | grant reqcyc m_respcyc err
    tbl[0]  = '{2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // contention, ptr 0 -> master 0
    tbl[1]  = '{2'b00, 2'b10, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0}; // granted, master 0 goes busy
    tbl[2]  = '{2'b00, 2'b10, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0};
    tbl[3]  = '{2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0}; // idle but response pending
    tbl[4]  = '{2'b00, 2'b11, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0};
    tbl[5]  = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0}; // release: response dropped
    tbl[6]  = '{2'b11, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0}; // idle, ptr 1 -> master 1
    tbl[7]  = '{2'b01, 2'b01, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0};
    tbl[8]  = '{2'b01, 2'b01, 1'b1, 2'b10, 1'b1, 2'b10, 1'b0}; // response routed to master 1
    tbl[9]  = '{2'b01, 2'b11, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0};
    tbl[10] = '{2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    tbl[11] = '{2'b01, 2'b11, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    tbl[12] = '{2'b00, 2'b11, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0};

    reset = 1'b1;
    m_busreq = '0; m_busidle = '1; m_reqcyc = 2'b11; m_respack = '0;
    m_req = {req1, req0}; m_reqtag = {13'h1B1, 13'h0A0};
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = 64'hDEAD_BEEF_0000_0001; bus_resptag = 13'h5;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_grant", m_busgrant, 2'b00);
    chk("reset_err", arb_error, 1'b0);

    // Directed table: single transaction, contention, response routing, release.
    for (int r = 0; r < 13; r++) begin
      @(negedge clk);
      m_busreq = tbl[r].busreq;
      m_busidle = tbl[r].busidle;
      bus_respcyc = tbl[r].respcyc;
      #1;
      $display("row %0d: busreq=%b idle=%b respcyc=%b grant=%b bus_reqcyc=%b m_respcyc=%b",
               r, m_busreq, m_busidle, bus_respcyc, m_busgrant, bus_reqcyc, m_respcyc);
      exp_req = (tbl[r].exp_grant == 2'b01) ? req0 : (tbl[r].exp_grant == 2'b10) ? req1 : '0;
      chk($sformatf("row%0d_grant", r), m_busgrant, tbl[r].exp_grant);
      chk($sformatf("row%0d_reqcyc", r), bus_reqcyc, tbl[r].exp_reqcyc);
      chk($sformatf("row%0d_mrespcyc", r), m_respcyc, tbl[r].exp_mresp);
      chk($sformatf("row%0d_err", r), arb_error, tbl[r].exp_err);
      chk($sformatf("row%0d_busreq", r), bus_req, exp_req);
      if (r == 8) chk("row8_mresp", m_resp, 64'hDEAD_BEEF_0000_0001);
    end

    // Start timeout: master 0 granted but never starts.
    do_reset();
    m_busreq = 2'b01; m_busidle = 2'b11;
    @(negedge clk);
    m_busreq = 2'b10;
    held = 0;
    #1;
    while (m_busgrant == 2'b01 && held < 40) begin
      held++;
      @(negedge clk);
      #1;
    end
    $display("timeout: grant held %0d cycles, arb_error=%b", held, arb_error);
    chk("timeout_len", held, ST);
    chk("timeout_err", arb_error, 1'b1);
    @(negedge clk); #1;
    chk("timeout_idle_grant", m_busgrant, 2'b00);
    @(negedge clk); #1;
    chk("timeout_regrant_m1", m_busgrant, 2'b10);

    // Reset while BUSY with bus_reqcyc asserted.
    @(negedge clk);
    m_busidle = 2'b01;
    @(negedge clk); #1;
    chk("busy_reqcyc", bus_reqcyc, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_comb_reqcyc", bus_reqcyc, 1'b0);
    @(negedge clk);
    reset = 1'b0; m_busreq = 2'b11; m_busidle = 2'b11;
    #1;
    $display("reset in busy: grant=%b bus_reqcyc=%b arb_error=%b", m_busgrant, bus_reqcyc, arb_error);
    chk("rst_grant", m_busgrant, 2'b00);
    chk("rst_err", arb_error, 1'b0);
    chk("rst_reqcyc", bus_reqcyc, 1'b0);
    @(negedge clk); #1;
    chk("rst_ptr0", m_busgrant, 2'b01);

    // Owner never returns idle.
    m_busreq = 2'b00; m_busidle = 2'b10;
    @(negedge clk);
`ifdef SYSBUS_ARB_WDOG_EN
    held = 0;
    #1;
    while (m_busgrant == 2'b01 && held < 200) begin
      held++;
      @(negedge clk);
      #1;
    end
    $display("watchdog: busy held %0d cycles, arb_error=%b", held, arb_error);
    chk("wdog_len", held, WD);
    chk("wdog_err", arb_error, 1'b1);
`else
    repeat (100) @(negedge clk);
    #1;
    $display("no watchdog: grant=%b after 100 busy cycles", m_busgrant);
    chk("nowdog_hold", m_busgrant, 2'b01);
    chk("nowdog_err", arb_error, 1'b0);
`endif

    // Random stimulus against the behavioural model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      m_busreq = N'($urandom);
      for (int i = 0; i < N; i++) m_busidle[i] = ($urandom_range(0, 7) != 0);
      m_reqcyc = N'($urandom);
      m_respack = N'($urandom);
      m_req = {$urandom, $urandom, $urandom, $urandom};
      m_reqtag = (N*TW)'($urandom);
      bus_reqack = $urandom_range(0, 1) == 1;
      bus_respcyc = $urandom_range(0, 1) == 1;
      bus_resp = {$urandom, $urandom};
      bus_resptag = TW'($urandom);
      #1;
      model_check();
      @(posedge clk);
      model_step();
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
